// File: rtl/fir_tdm_mc.sv
// Time-multiplexed multi-channel FIR: one shared MAC, per-channel circular delay lines,
// runtime-loadable coefficients, ready/valid on both sides, round + saturate on output.
module fir_tdm_mc #(
  parameter int N_TAPS      = 16,
  parameter int N_CH        = 2,
  parameter int IN_WIDTH    = 16,
  parameter int IN_FRAC     = 11,
  parameter int COEFF_WIDTH = 16,
  parameter int COEFF_FRAC  = 14,
  parameter int OUT_WIDTH   = 16,
  parameter int OUT_FRAC    = 14,
  parameter int ACC_WIDTH   = IN_WIDTH + COEFF_WIDTH + $clog2(N_TAPS),
  parameter bit ROUND_EN    = 1'b1,
  parameter int CH_W        = (N_CH > 1) ? $clog2(N_CH) : 1,
  parameter int TAP_W       = $clog2(N_TAPS)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [CH_W-1:0]        in_ch,
  input  logic [IN_WIDTH-1:0]    sample_in,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [CH_W-1:0]        out_ch,
  output logic [OUT_WIDTH-1:0]   sample_out,
  output logic                   out_sat,
  input  logic                   coef_we,
  input  logic [TAP_W-1:0]       coef_addr,
  input  logic [COEFF_WIDTH-1:0] coef_data,
  output logic                   coef_ready,
  input  logic                   flush,
  output logic                   busy
);
  localparam int SHIFT = IN_FRAC + COEFF_FRAC - OUT_FRAC;
  localparam int PW    = IN_WIDTH + COEFF_WIDTH;
  localparam int TW    = ACC_WIDTH + 1;
  localparam logic [TAP_W-1:0] TAP_LAST = TAP_W'(N_TAPS - 1);
  localparam logic [CH_W-1:0]  CH_LAST  = CH_W'(N_CH - 1);
  localparam logic signed [TW-1:0] RND  = ROUND_EN ? TW'(longint'(1) <<< (SHIFT - 1)) : '0;
  localparam logic signed [TW-1:0] OMAX = TW'((longint'(1) <<< (OUT_WIDTH - 1)) - 1);
  localparam logic signed [TW-1:0] OMIN = TW'(-(longint'(1) <<< (OUT_WIDTH - 1)));

  generate
    if (SHIFT < 1) begin : g_shift_chk
      $error("fir_tdm_mc: IN_FRAC+COEFF_FRAC-OUT_FRAC must be >= 1");
    end
    if (N_TAPS < 2) begin : g_taps_chk
      $error("fir_tdm_mc: N_TAPS must be >= 2");
    end
  endgenerate

  typedef enum logic [2:0] {CLEAR, IDLE, MAC, FMT, OUT} state_t;
  state_t state, state_n;

  logic signed [IN_WIDTH-1:0]    dl   [N_CH][N_TAPS];
  logic signed [COEFF_WIDTH-1:0] coef [N_TAPS];
  logic [TAP_W-1:0]              wptr [N_CH];
  logic [TAP_W-1:0]              clr_tap, k, rd_idx, wp;
  logic [CH_W-1:0]               clr_ch, ch;
  logic signed [ACC_WIDTH-1:0]   acc;
  logic signed [PW-1:0]          prod;
  logic signed [TW-1:0]          t, y;
  logic [OUT_WIDTH-1:0]          y_sat;
  logic                          sat_n, ch_ok, coef_ok, accept, clr_last, k_last;

  assign ch_ok    = {1'b0, in_ch} < (CH_W + 1)'(N_CH);
  assign coef_ok  = {1'b0, coef_addr} < (TAP_W + 1)'(N_TAPS);
  assign accept   = (state == IDLE) && in_valid && !flush;
  assign clr_last = (clr_tap == TAP_LAST) && (clr_ch == CH_LAST);
  assign k_last   = (k == TAP_LAST);

  // Newest sample sits at wptr (not yet advanced), so tap k reads wptr-k modulo N_TAPS.
  assign wp     = wptr[ch];
  assign rd_idx = (wp >= k) ? (wp - k) : (wp + TAP_W'(N_TAPS) - k);
  assign prod   = PW'(dl[ch][rd_idx]) * PW'(coef[k]);
  assign t      = TW'(acc) + RND;
  assign y      = t >>> SHIFT;

  always_comb begin
    sat_n = 1'b0;
    y_sat = y[OUT_WIDTH-1:0];
    if (y > OMAX) begin
      sat_n = 1'b1;
      y_sat = OMAX[OUT_WIDTH-1:0];
    end else if (y < OMIN) begin
      sat_n = 1'b1;
      y_sat = OMIN[OUT_WIDTH-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state <= CLEAR;
    else     state <= state_n;
  end

  always_comb begin
    state_n = state;
    unique case (state)
      CLEAR:   if (clr_last) state_n = IDLE;
      IDLE:    if (flush) state_n = CLEAR;
               else if (in_valid && ch_ok) state_n = MAC;
      MAC:     if (k_last) state_n = FMT;
      FMT:     state_n = OUT;
      OUT:     if (out_ready) state_n = IDLE;
      default: state_n = CLEAR;
    endcase
  end

  always_comb begin
    in_ready   = (state == IDLE);
    coef_ready = (state == IDLE);
    busy       = (state != IDLE);
    out_valid  = (state == OUT);
  end

  // Delay-line storage has no reset; CLEAR sweeps it after every reset or flush.
  always_ff @(posedge clk) begin
    if (state == CLEAR)         dl[clr_ch][clr_tap] <= '0;
    else if (accept && ch_ok)   dl[in_ch][wptr[in_ch]] <= sample_in;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      clr_tap    <= '0;
      clr_ch     <= '0;
      k          <= '0;
      ch         <= '0;
      acc        <= '0;
      sample_out <= '0;
      out_ch     <= '0;
      out_sat    <= 1'b0;
      for (int i = 0; i < N_TAPS; i++) coef[i] <= '0;
      for (int i = 0; i < N_CH; i++)   wptr[i] <= '0;
    end else begin
      unique case (state)
        CLEAR: begin
          for (int i = 0; i < N_CH; i++) wptr[i] <= '0;
          if (clr_last) begin
            clr_tap <= '0;
            clr_ch  <= '0;
          end else if (clr_tap == TAP_LAST) begin
            clr_tap <= '0;
            clr_ch  <= clr_ch + CH_W'(1);
          end else begin
            clr_tap <= clr_tap + TAP_W'(1);
          end
        end
        IDLE: begin
          if (coef_we && coef_ok) coef[coef_addr] <= coef_data;
          if (accept && ch_ok) begin
            ch  <= in_ch;
            acc <= '0;
            k   <= '0;
          end
        end
        MAC: begin
          acc <= acc + ACC_WIDTH'(prod);
          if (k_last) begin
            k        <= '0;
            wptr[ch] <= (wp == TAP_LAST) ? '0 : wp + TAP_W'(1);
          end else begin
            k <= k + TAP_W'(1);
          end
        end
        FMT: begin
          sample_out <= y_sat;
          out_sat    <= sat_n;
          out_ch     <= ch;
        end
        default: ;
      endcase
    end
  end
endmodule
